sara_dar_recovery_ctrl: RTL and testbench
=========================================

Name: sara_dar_recovery_ctrl

Overview:
- Sequencer for one shared SARA_DAR approximate adder instance (external to this block).
- Accepts operand pairs on a valid/ready handshake and first runs each add in speculative mode (carryoutselect=0).
- In accurate mode, it re-runs the add in corrected mode (carryoutselect=1) only when the speculation window shows a possible carry error.
- Keeps a saturating count of recoveries for error-rate profiling.

Parameters:
- SIZE, 16: operand/sum width; vectors indexed [SIZE:1].
- groupsize, 8: adder group width; group boundaries sit above bits k*groupsize, for k=1..SIZE/groupsize-1.
- window, 2: speculation window width below each boundary.
- CNTW, 16: recovery counter width.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand request.
- IN_READY  output  1  block can accept operands.
- A  input  SIZE  operand A.
- B  input  SIZE  operand B.
- CIN  input  1  carry in.
- MODE  input  1  0 = approximate only, 1 = accurate with recovery; sampled on accept.
- ADD_A  output  SIZE  to adder A.
- ADD_B  output  SIZE  to adder B.
- ADD_CIN  output  1  to adder CIN.
- ADD_SEL  output  1  to adder carryoutselect.
- ADD_SUM  input  SIZE  from adder SUM (combinational).
- ADD_COUT  input  1  from adder COUT.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer takes result.
- SUM  output  SIZE  registered result.
- COUT  output  1  registered carry out.
- OUT_APPROX  output  1  result is uncorrected and at risk of error.
- REC_CNT  output  CNTW  recoveries performed, saturating.

Behaviour:
- Reset values (async, RST_N=0): state IDLE, IN_READY=1, OUT_VALID=0, SUM=0, COUT=0, OUT_APPROX=0, REC_CNT=0, ADD_*=0, internal operand registers=0.
- FSM states: IDLE, SPEC, RECOV, HOLD.
- IDLE:
  - IN_READY=1.
  - On IN_VALID=1, latch A, B, CIN and MODE, then go to SPEC.
- SPEC (one cycle):
  - ADD_A/ADD_B/ADD_CIN driven from the latched registers, ADD_SEL=0.
  - Compute RISK = OR over all boundaries of (AND of (A^B) over the `window` bits just below the boundary). For the defaults this is bits 8:7 in [16:1] indexing.
  - At the clock edge:
    - If MODE=1 and RISK=1, go to RECOV.
    - Otherwise capture ADD_SUM/ADD_COUT into SUM/COUT, set OUT_APPROX=RISK&~MODE, set OUT_VALID=1, go to HOLD.
- RECOV (one cycle):
  - ADD_SEL=1, operands unchanged.
  - At the edge, capture SUM/COUT, set OUT_APPROX=0, increment REC_CNT (saturating at all-ones), set OUT_VALID=1, go to HOLD.
- HOLD:
  - OUT_VALID=1; SUM, COUT and OUT_APPROX are stable.
  - When OUT_READY=1, clear OUT_VALID at the edge and go to IDLE.
  - No new accept happens in the same cycle; the next accept is possible one cycle later.
- IN_READY=1 only in IDLE.
- ADD_SEL=0 outside RECOV.
- ADD_* hold the last operands outside SPEC/RECOV.
- Latency, from the accept edge to OUT_VALID high: 2 edges without recovery, 3 edges with recovery.
- Throughput: one op per 3 cycles (no recovery) or 4 cycles (with recovery), given OUT_READY=1.
- A change of MODE or the operand inputs after accept has no effect on the op in flight.
- Reset asserted mid-op (SPEC, RECOV or HOLD) aborts the op immediately. The result is lost and REC_CNT clears.

Test Plan:
- Reset with RST_N=0 asserted asynchronously between edges: all outputs read 0 and IN_READY=1 immediately.
- MODE=1, A=0x01E8, B=0x005F, CIN=0: RISK=0, ADD_SEL never 1, SUM=0x0247, COUT=0, OUT_APPROX=0, OUT_VALID 2 edges after accept, REC_CNT=0.
- MODE=1, A=0x00FF, B=0x0001, CIN=0: RISK=1, one RECOV cycle with ADD_SEL=1, SUM=0x0100, COUT=0, OUT_APPROX=0, REC_CNT=1, OUT_VALID 3 edges after accept.
- MODE=0, A=0xF1E0, B=0xF000: RISK=1 but no RECOV; SUM/COUT equal the adder's SEL=0 output, OUT_APPROX=1, REC_CNT unchanged. Repeat with MODE=1: SUM=0xE1E0, COUT=1, REC_CNT increments.
- Backpressure: OUT_READY=0 for 5 cycles in HOLD. OUT_VALID and SUM stay stable, IN_READY=0, and IN_VALID is ignored. Releasing OUT_READY returns the FSM to IDLE and IN_READY rises the next cycle.
- Reset pulse during RECOV: no OUT_VALID is produced and REC_CNT=0. Force REC_CNT to 0xFFFF via repeated recoveries (or a small CNTW): it saturates and does not wrap.

Source files
------------

// File: rtl/sara_dar_recovery_ctrl.sv
// rtl/sara_dar_recovery_ctrl.sv - speculate-then-recover sequencer for a shared SARA_DAR adder
module sara_dar_recovery_ctrl #(
    parameter int SIZE      = 16,
    parameter int groupsize = 8,
    parameter int window    = 2,
    parameter int CNTW      = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [SIZE:1]   A,
    input  logic [SIZE:1]   B,
    input  logic            CIN,
    input  logic            MODE,
    output logic [SIZE:1]   ADD_A,
    output logic [SIZE:1]   ADD_B,
    output logic            ADD_CIN,
    output logic            ADD_SEL,
    input  logic [SIZE:1]   ADD_SUM,
    input  logic            ADD_COUT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SIZE:1]   SUM,
    output logic            COUT,
    output logic            OUT_APPROX,
    output logic [CNTW-1:0] REC_CNT
);

    typedef enum logic [1:0] {IDLE, SPEC, RECOV, HOLD} state_t;

    localparam int NB = SIZE / groupsize - 1;

    state_t          r_state;
    state_t          w_next;
    logic [SIZE:1]   r_a;
    logic [SIZE:1]   r_b;
    logic            r_cin;
    logic            r_mode;
    logic [SIZE:1]   r_sum;
    logic            r_cout;
    logic            r_approx;
    logic [CNTW-1:0] r_cnt;
    logic [SIZE:1]   w_diff;
    logic [NB-1:0]   w_bnd;
    logic            w_risk;
    logic            w_recover;

    // A carry can only be mispredicted where every window bit below a boundary propagates.
    assign w_diff = r_a ^ r_b;

    genvar k;
    generate
        for (k = 1; k <= NB; k++) begin : g_bnd
            assign w_bnd[k-1] = &w_diff[k*groupsize -: window];
        end
    endgenerate

    assign w_risk    = |w_bnd;
    assign w_recover = r_mode & w_risk;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (IN_VALID) w_next = SPEC;
            SPEC:    w_next = w_recover ? RECOV : HOLD;
            RECOV:   w_next = HOLD;
            HOLD:    if (OUT_READY) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_mode   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_approx <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_a    <= A;
                        r_b    <= B;
                        r_cin  <= CIN;
                        r_mode <= MODE;
                    end
                end
                SPEC: begin
                    if (!w_recover) begin
                        r_sum    <= ADD_SUM;
                        r_cout   <= ADD_COUT;
                        r_approx <= w_risk & ~r_mode;
                    end
                end
                RECOV: begin
                    r_sum    <= ADD_SUM;
                    r_cout   <= ADD_COUT;
                    r_approx <= 1'b0;
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IN_READY   = (r_state == IDLE);
    assign OUT_VALID  = (r_state == HOLD);
    assign ADD_SEL    = (r_state == RECOV);
    assign ADD_A      = r_a;
    assign ADD_B      = r_b;
    assign ADD_CIN    = r_cin;
    assign SUM        = r_sum;
    assign COUT       = r_cout;
    assign OUT_APPROX = r_approx;
    assign REC_CNT    = r_cnt;

endmodule

// File: tb/tb_sara_dar_recovery_ctrl.sv
// tb/tb_sara_dar_recovery_ctrl.sv - randomized self-checking bench for sara_dar_recovery_ctrl
module tb_sara_dar_recovery_ctrl;

    localparam int SIZE = 16;
    localparam int G    = 8;
    localparam int W    = 2;
    localparam int CNTW = 4;
    localparam int MAXC = (1 << CNTW) - 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a_in;
    logic [SIZE-1:0] b_in;
    logic            cin_in;
    logic            mode_in;
    logic [SIZE-1:0] add_a;
    logic [SIZE-1:0] add_b;
    logic            add_cin;
    logic            add_sel;
    logic [SIZE-1:0] add_sum;
    logic            add_cout;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] sum;
    logic            cout;
    logic            out_approx;
    logic [CNTW-1:0] rec_cnt;

    int n_tests;
    int n_fail;
    int exp_cnt;

    sara_dar_recovery_ctrl #(.SIZE(SIZE), .groupsize(G), .window(W), .CNTW(CNTW)) dut (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a_in), .B(b_in), .CIN(cin_in), .MODE(mode_in),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin), .ADD_SEL(add_sel),
        .ADD_SUM(add_sum), .ADD_COUT(add_cout),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SUM(sum), .COUT(cout), .OUT_APPROX(out_approx), .REC_CNT(rec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder stand-in: speculative mode predicts the group carry from the window bits alone.
    function automatic logic [SIZE:0] adder_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                                   input logic c, input logic sel);
        logic [8:0] lo;
        logic [8:0] hi;
        logic [2:0] win;
        logic       sc;
        lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, c};
        win = {1'b0, a[7:6]} + {1'b0, b[7:6]};
        sc  = sel ? lo[8] : win[2];
        hi  = {1'b0, a[15:8]} + {1'b0, b[15:8]} + {8'd0, sc};
        return {hi[8], hi[7:0], lo[7:0]};
    endfunction

    assign {add_cout, add_sum} = adder_model(add_a, add_b, add_cin, add_sel);

    function automatic logic ref_risk(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int d;
        ref_risk = 1'b0;
        d = int'(a ^ b);
        for (int k = 1; k < SIZE / G; k++) begin
            if (((d >> (k * G - W)) & ((1 << W) - 1)) == ((1 << W) - 1)) ref_risk = 1'b1;
        end
    endfunction

    task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic c, input logic m, input int hold);
        logic [SIZE:0]   r;
        logic [SIZE-1:0] es;
        logic            ec;
        logic            ea;
        logic            risk;
        logic            recov;
        int              lat;
        int              sel_cycles;
        bit              opnd_ok;
        bit              hold_ok;
        risk  = ref_risk(a, b);
        recov = m & risk;
        if (recov) r = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, c};
        else       r = adder_model(a, b, c, 1'b0);
        es = r[SIZE-1:0];
        ec = r[SIZE];
        ea = risk & ~m;
        if (recov && exp_cnt < MAXC) exp_cnt++;

        @(negedge clk);
        lat = 0;
        while (!in_ready && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1; a_in = a; b_in = b; cin_in = c; mode_in = m; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a_in = SIZE'($urandom); b_in = SIZE'($urandom);
        cin_in = 1'($urandom); mode_in = ~m;
        lat = 1; sel_cycles = 0; opnd_ok = 1'b1;
        while (!out_valid && lat < 10) begin
            if (add_sel) sel_cycles++;
            if (add_a !== a || add_b !== b || add_cin !== c) opnd_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat != (recov ? 3 : 2)) begin
            n_fail++;
            $display("FAIL latency: a=%h b=%h mode=%b got %0d expected %0d", a, b, m, lat, recov ? 3 : 2);
        end
        n_tests++;
        if (sum !== es || cout !== ec) begin
            n_fail++;
            $display("FAIL sum: a=%h b=%h cin=%b mode=%b got %b_%h expected %b_%h", a, b, c, m, cout, sum, ec, es);
        end
        n_tests++;
        if (out_approx !== ea) begin
            n_fail++;
            $display("FAIL out_approx: a=%h b=%h mode=%b got %b expected %b", a, b, m, out_approx, ea);
        end
        n_tests++;
        if (sel_cycles != int'(recov)) begin
            n_fail++;
            $display("FAIL sel_cycles: a=%h b=%h mode=%b got %0d expected %0d", a, b, m, sel_cycles, int'(recov));
        end
        n_tests++;
        if (!opnd_ok) begin
            n_fail++;
            $display("FAIL adder_operands: a=%h b=%h got changed operands expected latched values", a, b);
        end
        n_tests++;
        if (rec_cnt !== CNTW'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rec_cnt: got %0d expected %0d", rec_cnt, exp_cnt);
        end

        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a_in = SIZE'($urandom); b_in = SIZE'($urandom);
            @(negedge clk);
            if (out_valid !== 1'b1 || sum !== es || in_ready !== 1'b0 || out_approx !== ea) hold_ok = 1'b0;
        end
        if (hold > 0) begin
            n_tests++;
            if (!hold_ok) begin
                n_fail++;
                $display("FAIL backpressure_hold: got unstable output or in_ready=%b expected stable hold", in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: out_valid=%b in_ready=%b expected 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_approx !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b out_approx=%b expected 1 0 0", in_ready, out_valid, out_approx);
        end
        n_tests++;
        if (sum !== '0 || cout !== 1'b0 || rec_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_result: sum=%h cout=%b rec_cnt=%0d expected 0", sum, cout, rec_cnt);
        end
        n_tests++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0 || add_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_adder: add_a=%h add_b=%h cin=%b sel=%b expected 0", add_a, add_b, add_cin, add_sel);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_directed();
        run_op(16'h01E8, 16'h005F, 1'b0, 1'b1, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hF1E0, 16'hF000, 1'b0, 1'b0, 0);
        run_op(16'hF1E0, 16'hF000, 1'b0, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        run_op(16'h1234, 16'h00C0, 1'b1, 1'b0, 5);
    endtask

    task automatic test_random();
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        for (int i = 0; i < 40; i++) begin
            a = SIZE'($urandom);
            b = SIZE'($urandom);
            if ($urandom_range(0, 1) == 1) b[7:6] = ~a[7:6];
            run_op(a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_recov();
        bit quiet;
        @(negedge clk);
        in_valid = 1'b1; a_in = 16'h00FF; b_in = 16'h0001; cin_in = 1'b0; mode_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        n_tests++;
        if (add_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL recov_entry: add_sel=%b expected 1", add_sel);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || rec_cnt !== '0 || in_ready !== 1'b1 || add_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_recov: out_valid=%b rec_cnt=%0d in_ready=%b add_sel=%b expected 0 0 1 0",
                     out_valid, rec_cnt, in_ready, add_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL aborted_op: out_valid went high expected no result");
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < MAXC + 4; i++) begin
            run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 0);
        end
        n_tests++;
        if (rec_cnt !== CNTW'(MAXC)) begin
            n_fail++;
            $display("FAIL saturation: rec_cnt=%0d expected %0d", rec_cnt, MAXC);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_cnt = 0;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; cin_in = 1'b0; mode_in = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_recov();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
